inst_fetch: RTL and testbench

Instruction fetch unit upstream of the cpu decode stage, supplying its instruction input. It issues word-address requests to a pipelined instruction memory and tracks in-flight requests. Returned words are buffered in a small prefetch FIFO that presents one instruction per cycle. On a branch/jump redirect it flushes buffered and in-flight words and restarts fetching at the new PC.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/inst_fetch.sv | 126 ++++++++++++
 tb/tb_inst_fetch.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU front end: instruction/PC widths, the NOP
// encoding and the fetch FSM states.
package cpu_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for fetched {pc, instruction} pairs. The head is read
// combinationally. A flush clears it synchronously and takes priority over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PC_W + INST_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_inc;
  logic [AW:0]      w_dec;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign w_inc     = {{AW{1'b0}}, w_do_push};
  assign w_dec     = {{AW{1'b0}}, w_do_pop};

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + w_inc - w_dec;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit. It issues credit-limited word requests to a pipelined memory
// and buffers in-order responses. A redirect flushes the FIFO and discards in-flight words.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_redirect,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic              o_busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int FW = PC_W + INST_W;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
  localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUT);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_resp_pc;
  logic [OW-1:0]   r_out;
  logic [OW-1:0]   r_discard;

  logic            w_req;
  logic            w_issue;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_credit_used;
  logic [FW-1:0]   w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_fifo_count;

  assign w_credit_used = 32'(w_fifo_count) + 32'(r_out);

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = RUN;
      end
      RUN: begin
        // Reserving FIFO space for every in-flight word means a response never finds it full.
        w_req = !i_redirect && (w_credit_used < DEPTH_U) && (32'(r_out) < MAX_OUT_U);
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  assign w_issue = w_req && i_imem_gnt;
  // A response with no outstanding request cannot belong to this unit.
  assign w_rsp   = i_imem_rvalid && (r_out != '0);
  assign w_push  = w_rsp && (r_discard == '0) && !i_redirect;
  assign w_pop   = o_inst_valid && i_inst_ready && !i_redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_discard  <= '0;
    end else begin
      r_out <= r_out + OW'(w_issue) - OW'(w_rsp);
      if (i_redirect) begin
        r_fetch_pc <= i_redirect_pc;
        r_resp_pc  <= i_redirect_pc;
        // Everything still in flight is stale, including words already marked for discard.
        r_discard  <= r_out - OW'(w_rsp);
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd1;
        if (w_rsp) begin
          if (r_discard != '0) r_discard <= r_discard - OW'(1);
          else                 r_resp_pc <= r_resp_pc + 32'd1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_push),
    .i_wdata ({r_resp_pc, i_imem_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_fetch_pc;
  assign o_inst_valid = !w_empty;
  assign o_inst       = o_inst_valid ? w_head[INST_W-1:0] : NOP_INST;
  assign o_pc         = o_inst_valid ? w_head[FW-1:INST_W] : '0;
  assign o_busy       = (r_out != '0) || !w_empty;

  logic w_unused;
  assign w_unused = w_full;
endmodule

// File: tb/tb_inst_fetch.sv
// Randomised bench for inst_fetch. A pipelined memory model and an in-order stream
// model predict the next consumed PC/instruction and the next granted fetch address.
module tb_inst_fetch;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic        o_busy;

  inst_fetch #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_inst_valid  (o_inst_valid),
    .i_inst_ready  (i_inst_ready),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned lat = 1;
  int unsigned gnt_pct = 100;
  int unsigned cyc_n = 0;
  int          tb_out = 0;
  int          issued = 0;
  int          consumed = 0;
  logic [31:0] exp_pc, exp_addr, hd_pc, rq_addr;
  logic        obs_req, obs_valid, obs_busy, obs_pop, obs_gnt;
  logic [31:0] obs_addr, obs_pc, obs_inst;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic model_reset();
    mem_q.delete();
    tb_out   = 0;
    issued   = 0;
    consumed = 0;
    exp_pc   = RESET_PC;
    exp_addr = RESET_PC;
  endtask

  // One clock cycle: drive stimulus and memory response, sample outputs, advance the models.
  task automatic cyc(input bit start, input bit redir, input logic [31:0] rpc, input bit ready);
    @(negedge clk);
    i_start       = start;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_inst_ready  = ready;
    i_imem_gnt    = ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = memfn(mem_q[0].addr);
      void'(mem_q.pop_front());
      tb_out--;
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    #1;
    obs_req   = o_imem_req;
    obs_addr  = o_imem_addr;
    obs_valid = o_inst_valid;
    obs_pc    = o_pc;
    obs_inst  = o_inst;
    obs_busy  = o_busy;
    obs_gnt   = i_imem_gnt;
    hd_pc     = exp_pc;
    rq_addr   = exp_addr;
    obs_pop   = obs_valid && ready && !redir;
    if (obs_pop) begin
      exp_pc = exp_pc + 32'd1;
      consumed++;
    end
    if (obs_req && obs_gnt) begin
      mem_q.push_back('{obs_addr, cyc_n + lat});
      tb_out++;
      issued++;
      exp_addr = exp_addr + 32'd1;
    end
    if (redir) begin
      exp_pc   = rpc;
      exp_addr = rpc;
    end
    cyc_n++;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1'b0 || o_imem_addr !== RESET_PC || o_inst !== 32'h0 ||
        o_pc !== 32'h0 || o_inst_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h inst=%h pc=%h valid=%b busy=%b, required 0 %h 0 0 0 0",
               o_imem_req, o_imem_addr, o_inst, o_pc, o_inst_valid, o_busy, RESET_PC);
    end
    #2 i_rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (obs_req !== 1'b0 || obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_before_start: req=%b busy=%b valid=%b, required 0 0 0", obs_req, obs_busy, obs_valid);
      end
    end
  endtask

  task automatic test_start_stream();
    lat = 1; gnt_pct = 100;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle0_req: got %b, required 0", obs_req);
    end
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 1) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
          errors++;
          $display("FAIL start_first_req: req=%b addr=%h, required 1 %h", obs_req, obs_addr, RESET_PC);
        end
      end
      checks++;
      if (obs_valid !== (k >= 3)) begin
        errors++;
        $display("FAIL start_valid_timing: cycle %0d valid=%b, required %b", k, obs_valid, (k >= 3));
      end
      if (obs_pop) begin
        checks++;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL start_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b1 || tb_out != 0 || (issued - consumed) != DEPTH) begin
      errors++;
      $display("FAIL stall_buffered: req=%b valid=%b outstanding=%0d buffered=%0d, required 0 1 0 %0d",
               obs_req, obs_valid, tb_out, issued - consumed, DEPTH);
    end
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_pop) begin
        checks++;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL stall_release_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
      if (obs_req && obs_gnt) begin
        checks++;
        if (obs_addr !== rq_addr) begin
          errors++;
          $display("FAIL stall_resume_addr: got %h, required %h", obs_addr, rq_addr);
        end
      end
    end
  endtask

  task automatic test_latency();
    lat = 3; gnt_pct = 70;
    for (int k = 0; k < 200; k++) begin
      cyc(1'b0, 1'b0, 32'h0, ($urandom_range(99) < 70));
      checks++;
      if (tb_out > MAX_OUT || tb_out < 0) begin
        errors++;
        $display("FAIL latency_outstanding: got %0d, required 0..%0d", tb_out, MAX_OUT);
      end
      if (obs_pop) begin
        checks++;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL latency_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
      if (obs_req && obs_gnt) begin
        checks++;
        if (obs_addr !== rq_addr) begin
          errors++;
          $display("FAIL latency_addr: got %h, required %h", obs_addr, rq_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    bit got_first = 1'b0;
    lat = 3; gnt_pct = 0;
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    gnt_pct = 100;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      found = (tb_out == 2) && ((issued - consumed - tb_out) == 2);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirect_setup_timeout: outstanding=%0d buffered=%0d, required 2 2", tb_out, issued - consumed - tb_out);
    end
    cyc(1'b0, 1'b1, 32'h40, 1'b1);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_no_req: got %b, required 0", obs_req);
    end
    for (int k = 0; k < 25; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        checks++;
        if (obs_valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_flush_valid: got %b, required 0", obs_valid);
        end
      end
      if (!obs_valid) begin
        checks++;
        if (obs_inst !== 32'h0) begin
          errors++;
          $display("FAIL redirect_nop: got %h, required 00000000", obs_inst);
        end
      end
      if (obs_pop) begin
        checks++;
        if (!got_first && obs_pc !== 32'h40) begin
          errors++;
          $display("FAIL redirect_first_pc: got %h, required 00000040", obs_pc);
        end
        got_first = 1'b1;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL redirect_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
    end
    checks++;
    if (!got_first) begin
      errors++;
      $display("FAIL redirect_no_output: got no instruction after redirect, required one at 00000040");
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found = 1'b0;
    bit got_first = 1'b0;
    lat = 3; gnt_pct = 100;
    for (int k = 0; k < 30; k++) begin
      if (mem_q.size() == 2 && mem_q[0].due <= cyc_n) begin
        found = 1'b1;
        break;
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirect_rvalid_setup_timeout: outstanding=%0d, required 2 with a response due", tb_out);
    end
    cyc(1'b0, 1'b1, 32'h60, 1'b1);
    cyc(1'b0, 1'b1, 32'h80, 1'b1);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect2_no_req: got %b, required 0", obs_req);
    end
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_pop) begin
        checks++;
        if (!got_first && obs_pc !== 32'h80) begin
          errors++;
          $display("FAIL redirect2_first_pc: got %h, required 00000080", obs_pc);
        end
        got_first = 1'b1;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL redirect2_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
    end
    checks++;
    if (!got_first) begin
      errors++;
      $display("FAIL redirect2_no_output: got no instruction, required one at 00000080");
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    lat = 3; gnt_pct = 100;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      found = (tb_out == 2);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_setup_timeout: outstanding=%0d, required 2", tb_out);
    end
    @(negedge clk);
    #3 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_imem_req !== 1'b0 || o_imem_addr !== RESET_PC || o_inst !== 32'h0 ||
        o_pc !== 32'h0 || o_inst_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: req=%b addr=%h inst=%h pc=%h valid=%b busy=%b, required 0 %h 0 0 0 0",
               o_imem_req, o_imem_addr, o_inst, o_pc, o_inst_valid, o_busy, RESET_PC);
    end
    i_imem_rvalid = 1'b0;
    i_imem_gnt    = 1'b0;
    i_start       = 1'b0;
    i_redirect    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 i_rst_n = 1'b1;
    lat = 1;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 1) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
          errors++;
          $display("FAIL reset_mid_restart_req: req=%b addr=%h, required 1 %h", obs_req, obs_addr, RESET_PC);
        end
      end
      if (k == 3) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== RESET_PC) begin
          errors++;
          $display("FAIL reset_mid_restart_pc: valid=%b pc=%h, required 1 %h", obs_valid, obs_pc, RESET_PC);
        end
      end
      if (obs_pop) begin
        checks++;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL reset_mid_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
    end
  endtask

  task automatic test_idle_redirect();
    @(negedge clk);
    i_rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2 i_rst_n = 1'b1;
    lat = 1; gnt_pct = 100;
    cyc(1'b0, 1'b1, 32'h100, 1'b1);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_redirect_req: got %b, required 0", obs_req);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 1) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
          errors++;
          $display("FAIL idle_redirect_addr: req=%b addr=%h, required 1 00000100", obs_req, obs_addr);
        end
      end
      if (obs_pop) begin
        checks++;
        if (obs_pc !== hd_pc || obs_inst !== memfn(hd_pc)) begin
          errors++;
          $display("FAIL idle_redirect_stream: pc=%h inst=%h, required pc=%h inst=%h", obs_pc, obs_inst, hd_pc, memfn(hd_pc));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_stream();
    test_stall();
    test_latency();
    test_redirect();
    test_redirect_rvalid();
    test_reset_mid();
    test_idle_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
